lfsr: RTL and testbench

- 3-bit Galois-style linear feedback shift register with parallel load.
- Produces the maximal-length 7-state pseudo-random sequence.
- Used as a small pattern/sequence generator; state is observable directly on Q.
- One clock domain; asynchronous active-high reset.

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr_if.sv | 13 +
 rtl/lfsr.sv | 36 +++
 tb/tb_lfsr.sv | 133 +++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared width, tap position and next-state helper for the 3-bit Galois LFSR.
// Stage numbering is ascending [0:2], so stage 0 is the leftmost bit in literals.
package lfsr_pkg;

    localparam int LFSR_W    = 3;
    // The feedback XOR sits between stage 0 and stage 1.
    localparam int TAP_STAGE = 1;

    function automatic logic [0:LFSR_W-1] lfsr_next(input logic [0:LFSR_W-1] s);
        logic [0:LFSR_W-1] n;
        n            = {s[LFSR_W-1], s[0:LFSR_W-2]};
        n[TAP_STAGE] = s[TAP_STAGE-1] ^ s[LFSR_W-1];
        return n;
    endfunction

endpackage

// File: rtl/lfsr_if.sv
// Load/state bundle of the LFSR: parallel load value, load enable and state.
// The master drives R and L and observes Q; the LFSR itself is the slave.
interface lfsr_if;
    import lfsr_pkg::*;

    logic [0:LFSR_W-1] R;
    logic              L;
    logic [0:LFSR_W-1] Q;

    modport master (output R, output L, input  Q);
    modport slave  (input  R, input  L, output Q);

endinterface

// File: rtl/lfsr.sv
// 3-bit Galois LFSR with synchronous parallel load; maximal 7-state sequence.
// Loading 000 parks the register in the lock-up state until reloaded or reset.
module lfsr
    import lfsr_pkg::*;
#(
    parameter logic [0:LFSR_W-1] RESET_VALUE = 3'b001
) (
    input  logic   Clock,
    input  logic   Reset,
    lfsr_if.slave  bus
);

    logic [0:LFSR_W-1] q_q;
    logic [0:LFSR_W-1] q_d;

    // Load wins over shift; R only reaches the state through the flop.
    always_comb begin
        q_d = q_q;
        if (bus.L) begin
            q_d = bus.R;
        end else begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q = q_q;

endmodule

// File: tb/tb_lfsr.sv
// Scoreboard bench for lfsr: stimulus pushes expected states, a monitor pops them.
// The reference model walks the documented 7-state cycle rather than the tap equations.
module tb_lfsr;

    localparam logic [2:0] RST_VAL = 3'b001;
    localparam logic [2:0] CYC [7] = '{3'b001, 3'b110, 3'b011, 3'b111,
                                       3'b101, 3'b100, 3'b010};

    logic clk;
    logic rst;
    lfsr_if bus ();

    lfsr #(.RESET_VALUE(RST_VAL)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q [$];
    logic [2:0] model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model_next(input logic [2:0] s);
        for (int i = 0; i < 7; i++) begin
            if (CYC[i] == s) return CYC[(i + 1) % 7];
        end
        return 3'b000;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic l, input logic [2:0] r);
        bus.L = l;
        bus.R = r;
        model = l ? r : model_next(model);
        exp_q.push_back(model);
    endtask

    task automatic step(input logic l, input logic [2:0] r);
        @(negedge clk);
        apply(l, r);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) check("q_seq", bus.Q, exp_q.pop_front());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset dominates a pending load and holds the state across edges.
        rst   = 1'b1;
        bus.L = 1'b1;
        bus.R = 3'b111;
        #1;
        check("reset_imm", bus.Q, RST_VAL);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.Q, RST_VAL);
        end
        @(negedge clk);
        rst   = 1'b0;
        model = RST_VAL;
        apply(1'b1, 3'b111);

        // Full period from a load of 001.
        step(1'b1, 3'b001);
        for (int i = 0; i < 14; i++) step(1'b0, 3'($urandom));

        // Mid-sequence load then shift.
        step(1'b1, 3'b101);
        step(1'b0, 3'b000);
        step(1'b0, 3'b111);

        // Lock-up and exit by load.
        step(1'b1, 3'b000);
        for (int i = 0; i < 5; i++) step(1'b0, 3'($urandom));
        step(1'b1, 3'b010);
        step(1'b0, 3'b110);

        // Asynchronous reset between edges while shifting.
        for (int i = 0; i < 3; i++) step(1'b0, 3'($urandom));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("reset_async", bus.Q, RST_VAL);
        @(posedge clk);
        #1;
        check("reset_async_hold", bus.Q, RST_VAL);
        @(negedge clk);
        rst   = 1'b0;
        model = RST_VAL;
        apply(1'b0, 3'($urandom));

        // R toggling while L stays low.
        for (int i = 0; i < 20; i++) step(1'b0, 3'($urandom));

        // Randomized mix of loads and shifts.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 5) == 0), 3'($urandom));
        end

        @(negedge clk);
        bus.L = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
